// File: rtl/pk_a2_state_if.sv
`default_nettype none
// ============================================================================
//  Module   : pk_a2_state_if
//  Purpose  : Fetch / commit / init request bus and operand return bus for
//             the per-channel ADPCM A2 predictor state store.
//  Revision : 1.0  initial release
// ============================================================================
interface pk_a2_state_if #(
    parameter int NCH = 32
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // requests
    logic            fetch_valid;
    logic [CHW-1:0]  fetch_ch;
    logic [15:0]     DQSEZ;
    logic            commit_valid;
    logic [CHW-1:0]  commit_ch;
    logic [15:0]     A2T;
    logic            TR;
    logic            init_valid;
    logic [CHW-1:0]  init_ch;

    // responses
    logic            PK0;
    logic            PK1;
    logic            PK2;
    logic            SIGPK;
    logic [15:0]     A2;
    logic            out_valid;
    logic [15:0]     A2P;
    logic            commit_done;

    // state store side
    modport slave (
        input  fetch_valid, fetch_ch, DQSEZ,
        input  commit_valid, commit_ch, A2T, TR,
        input  init_valid, init_ch,
        output PK0, PK1, PK2, SIGPK, A2, out_valid, A2P, commit_done
    );

    // requester side
    modport master (
        output fetch_valid, fetch_ch, DQSEZ,
        output commit_valid, commit_ch, A2T, TR,
        output init_valid, init_ch,
        input  PK0, PK1, PK2, SIGPK, A2, out_valid, A2P, commit_done
    );
endinterface
`default_nettype wire

// File: rtl/pk_a2_state.sv
`default_nettype none
// ============================================================================
//  Module   : pk_a2_state
//  Purpose  : Per-channel storage of sign history (h1, h2) and limited A2
//             coefficient for an ADPCM predictor; returns update operands one
//             cycle after fetch, limits and writes back A2 on commit.
//  Revision : 1.0  initial release
// ============================================================================
module pk_a2_state #(
    parameter int NCH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         scan_in0,
    input  wire logic         scan_in1,
    input  wire logic         scan_in2,
    input  wire logic         scan_in3,
    input  wire logic         scan_in4,
    input  wire logic         scan_enable,
    input  wire logic         test_mode,
    output      logic         scan_out0,
    output      logic         scan_out1,
    output      logic         scan_out2,
    output      logic         scan_out3,
    output      logic         scan_out4,
    pk_a2_state_if.slave      bus
);
    localparam logic signed [15:0] c_a2_max = 16'sh3000;   //  12288
    localparam logic signed [15:0] c_a2_min = 16'shD000;   // -12288

    // per-channel state
    logic        r_h1  [NCH];
    logic        r_h2  [NCH];
    logic [15:0] r_a2r [NCH];

    // registered outputs
    logic        r_pk0;
    logic        r_pk1;
    logic        r_pk2;
    logic        r_sigpk;
    logic [15:0] r_a2;
    logic        r_out_valid;
    logic [15:0] r_a2p;
    logic        r_commit_done;

    logic [15:0] w_a2p;
    logic        w_init_hits_fetch;
    logic        w_commit_hits_fetch;

    // Scan chain is inserted at DFT time; only a gated pass-through exists here
    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

    assign w_init_hits_fetch   = bus.init_valid   && (bus.init_ch   == bus.fetch_ch);
    assign w_commit_hits_fetch = bus.commit_valid && (bus.commit_ch == bus.fetch_ch);

    // LIMC: clamp the unlimited A2 to +/-0x3000, tone trigger forces zero
    always_comb begin
        w_a2p = bus.A2T;
        if (bus.TR) begin
            w_a2p = 16'h0000;
        end else if ($signed(bus.A2T) > c_a2_max) begin
            w_a2p = c_a2_max;
        end else if ($signed(bus.A2T) < c_a2_min) begin
            w_a2p = c_a2_min;
        end
    end

    // Operand return, write-back and homing; later writes to the same
    // channel override earlier ones: commit < init < fetch sign history
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                r_h1[k]  <= 1'b0;
                r_h2[k]  <= 1'b0;
                r_a2r[k] <= 16'h0000;
            end
            r_pk0         <= 1'b0;
            r_pk1         <= 1'b0;
            r_pk2         <= 1'b0;
            r_sigpk       <= 1'b0;
            r_a2          <= 16'h0000;
            r_out_valid   <= 1'b0;
            r_a2p         <= 16'h0000;
            r_commit_done <= 1'b0;
        end else begin
            r_out_valid   <= bus.fetch_valid;
            r_commit_done <= bus.commit_valid;

            if (bus.fetch_valid) begin
                r_pk0   <= bus.DQSEZ[15];
                r_sigpk <= (bus.DQSEZ == 16'h0000);
                if (w_init_hits_fetch) begin
                    r_pk1 <= 1'b0;
                    r_pk2 <= 1'b0;
                    r_a2  <= 16'h0000;
                end else begin
                    r_pk1 <= r_h1[bus.fetch_ch];
                    r_pk2 <= r_h2[bus.fetch_ch];
                    r_a2  <= w_commit_hits_fetch ? w_a2p : r_a2r[bus.fetch_ch];
                end
            end

            if (bus.commit_valid) begin
                r_a2p                 <= w_a2p;
                r_a2r[bus.commit_ch]  <= w_a2p;
            end

            if (bus.init_valid) begin
                r_h1[bus.init_ch]  <= 1'b0;
                r_h2[bus.init_ch]  <= 1'b0;
                r_a2r[bus.init_ch] <= 16'h0000;
            end

            // a homed channel still records the sign of the sample just fetched
            if (bus.fetch_valid) begin
                r_h1[bus.fetch_ch] <= bus.DQSEZ[15];
                r_h2[bus.fetch_ch] <= w_init_hits_fetch ? 1'b0 : r_h1[bus.fetch_ch];
            end
        end
    end

    assign bus.PK0         = r_pk0;
    assign bus.PK1         = r_pk1;
    assign bus.PK2         = r_pk2;
    assign bus.SIGPK       = r_sigpk;
    assign bus.A2          = r_a2;
    assign bus.out_valid   = r_out_valid;
    assign bus.A2P         = r_a2p;
    assign bus.commit_done = r_commit_done;
endmodule
`default_nettype wire

// File: doc/pk_a2_state.md
PK_A2_STATE -- requirements
Module: pk_a2_state

Interface
REQ-001 SHALL have parameter NCH, default 32, meaning number of ADPCM channels held; NCH is a power of two, 2..32.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports scan_in0..scan_in4, scan_enable, test_mode  input  1 each  DFT scan controls; functional behaviour is defined only for test_mode=0 and scan_enable=0.
REQ-005 SHALL have ports scan_out0..scan_out4  output  1 each  DFT scan chain outputs.
REQ-006 SHALL have port fetch_valid  input  1  request for predictor-update operands of fetch_ch.
REQ-007 SHALL have port fetch_ch  input  log2(NCH)  channel index for fetch.
REQ-008 SHALL have port DQSEZ  input  16  two's-complement DQ+SEZ for the fetched channel.
REQ-009 SHALL have port commit_valid  input  1  write-back of updated A2 for commit_ch.
REQ-010 SHALL have port commit_ch  input  log2(NCH)  channel index for commit.
REQ-011 SHALL have port A2T  input  16  unlimited two's-complement A2 from the update stage.
REQ-012 SHALL have port TR  input  1  tone/transition trigger; forces A2 to zero on commit.
REQ-013 SHALL have port init_valid  input  1  per-channel homing: clear state of init_ch.
REQ-014 SHALL have port init_ch  input  log2(NCH)  channel to clear.
REQ-015 SHALL have ports PK0, PK1, PK2, SIGPK  output  1 each  registered sign history and zero flag for fetched channel.
REQ-016 SHALL have port A2  output  16  registered stored A2 for fetched channel.
REQ-017 SHALL have port out_valid  output  1  operands on PK0..A2 valid.
REQ-018 SHALL have port A2P  output  16  registered limited value last committed; commit_done output 1 pulses with it.

Function
REQ-019 SHALL hold per channel: h1, h2 (1 bit each), a2r (16 bit).
REQ-020 SHALL, on fetch_valid at edge N, drive at edge N+1 (one-cycle latency): PK0=DQSEZ[15], SIGPK=(DQSEZ==0), PK1=h1[ch], PK2=h2[ch], A2=a2r[ch], out_valid=1.
REQ-021 SHALL, on the same fetch edge, update h2[ch]<=h1[ch] and h1[ch]<=DQSEZ[15].
REQ-022 SHALL hold PK0..A2 unchanged and out_valid=0 in cycles without fetch_valid.
REQ-023 SHALL, on commit_valid, compute A2P by LIMC: A2T>0x3000 signed (12288) -> 0x3000; A2T<0xD000 signed (-12288) -> 0xD000; else A2T.
REQ-024 SHALL, when TR=1 with commit_valid, use A2P=0x0000 regardless of A2T.
REQ-025 SHALL write a2r[commit_ch]<=A2P, register A2P output, and pulse commit_done=1 one cycle after commit_valid.
REQ-026 SHALL, on fetch and commit of the same channel in one cycle, output A2 equal to the new A2P (write-first forwarding).
REQ-027 SHALL, on init_valid, clear h1, h2, a2r of init_ch to zero; init has priority over commit and fetch updates to that channel.
REQ-028 SHALL, on fetch and init of the same channel in one cycle, output PK1=PK2=0, A2=0, and leave h1=DQSEZ[15], h2=0.
REQ-029 SHALL process fetch, commit, init of different channels in one cycle independently.
REQ-030 SHALL treat all signed compares as 16-bit two's complement; no other arithmetic widths.

Reset
REQ-031 SHALL, on reset=1 at an edge, clear all h1, h2, a2r for every channel, and set PK0, PK1, PK2, SIGPK, out_valid, commit_done to 0 and A2, A2P to 0x0000.
REQ-032 SHALL have reset override fetch, commit and init in the same cycle; reset asserted mid-stream discards pending requests with no output pulse.

Verification
REQ-033 After reset, fetch ch3 DQSEZ=0x8001 three times -> out PK0/PK1/PK2 = 1/0/0, then 1/1/0, then 1/1/1; SIGPK=0; A2=0x0000.
REQ-034 Fetch ch5 DQSEZ=0x0000 -> SIGPK=1, PK0=0, out_valid=1 exactly one cycle after request.
REQ-035 Commit ch7 A2T=0x4000 -> A2P=0x3000; A2T=0x9000 -> 0xD000; A2T=0x1234 -> 0x1234; A2T=0x4000 with TR=1 -> 0x0000; subsequent fetch ch7 returns A2 equal to last A2P.
REQ-036 Same-cycle fetch and commit ch2 A2T=0x0100 -> A2=0x0100 on out; different channels same cycle -> fetch returns old a2r.
REQ-037 Load ch1 state (h1=h2=1, a2r=0x2000), init ch1 -> fetch ch1 returns PK1=PK2=0, A2=0x0000; ch0 state untouched.
REQ-038 Reset asserted in a cycle with fetch and commit -> next cycle out_valid=0, commit_done=0, all channels zero on later fetch.
